// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - parallel word input handshake for serial_pattern_tx
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - FIFO-buffered parallel-to-serial word transmitter
module serial_pattern_tx #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  serial_pattern_tx_if.slave     in_if,
  output logic                   out,
  output logic                   out_valid,
  output logic                   last,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             push, pop, final_bit;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even on the edge that pops; this keeps in_ready free of combinational paths.
  assign in_if.in_ready = (count != (PW+1)'(DEPTH));
  assign push           = in_if.in_valid && in_if.in_ready;
  assign final_bit      = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and pop decision: load from idle, or reload on the final bit
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (final_bit) begin
          if (count != '0) pop = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_if.in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Shift register and bit counter; the current bit always sits at the output end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      sreg    <= mem[rd_ptr];
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      sreg    <= (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
      bit_cnt <= final_bit ? '0 : bit_cnt + 1'b1;
    end
  end

  // Outputs decoded from registered state; reset clears them without a clock
  always_comb begin
    out_valid  = (state == SHIFT);
    out        = out_valid && ((MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0]);
    last       = final_bit;
    fifo_count = count;
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;
  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       o0, v0, l0, o1, v1, l1;
  logic [2:0] fc0, fc1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int pops1 = 0;

  bit rec_en = 1'b0;
  int max_cnt = 0;
  bit saw_notready = 1'b0;
  int prev_cnt = -1;
  int trans_seen = 0;

  always #5 CLK = ~CLK;

  serial_pattern_tx_if #(.WIDTH(W)) if0 ();
  serial_pattern_tx_if #(.WIDTH(W)) if1 ();

  serial_pattern_tx #(.WIDTH(W), .DEPTH(4), .MSB_FIRST(1)) dut0 (
    .CLK(CLK), .RESET(RESET), .in_if(if0),
    .out(o0), .out_valid(v0), .last(l0), .fifo_count(fc0)
  );

  serial_pattern_tx #(.WIDTH(W), .DEPTH(4), .MSB_FIRST(0)) dut1 (
    .CLK(CLK), .RESET(RESET), .in_if(if1),
    .out(o1), .out_valid(v1), .last(l1), .fifo_count(fc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid bit is matched against the head of the scoreboard
  always @(negedge CLK) begin
    logic [1:0] e;
    if (RESET) begin
      if (v0) begin
        if (q0.size() == 0) check("dut0 spurious out_valid", v0, 1'b0);
        else begin
          e = q0.pop_front();
          check("dut0 out", o0, e[1]);
          check("dut0 last", l0, e[0]);
        end
      end else begin
        check("dut0 idle out", {o0, l0}, 2'b00);
      end
      if (v1) begin
        if (q1.size() == 0) check("dut1 spurious out_valid", v1, 1'b0);
        else begin
          e = q1.pop_front();
          pops1++;
          check("dut1 out", o1, e[1]);
          check("dut1 last", l1, e[0]);
        end
      end else begin
        check("dut1 idle out", {o1, l1}, 2'b00);
      end
    end
  end

  // Occupancy recorder for the fill/overflow scenario
  always @(negedge CLK) begin
    if (rec_en) begin
      if (int'(fc0) > max_cnt) max_cnt = int'(fc0);
      if (!if0.in_ready) saw_notready = 1'b1;
      if (prev_cnt == 4 && fc0 != 3'd4) begin
        trans_seen++;
        check("full reload count", fc0, 3'd3);
        check("in_ready after reload", if0.in_ready, 1'b1);
      end
      prev_cnt = int'(fc0);
    end
  end

  // Hold a word until accepted, then queue its expected bit sequence
  task automatic push(input int which, input logic [W-1:0] d);
    bit rdy;
    bit done;
    done = 1'b0;
    @(negedge CLK);
    if (which == 0) begin if0.in_valid = 1'b1; if0.in_data = d; end
    else            begin if1.in_valid = 1'b1; if1.in_data = d; end
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = (which == 0) ? if0.in_ready : if1.in_ready;
      @(posedge CLK);
      if (rdy) done = 1'b1;
      else     @(negedge CLK);
    end
    #1;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    if (!done) check("push accept timeout", 1'b0, 1'b1);
    else begin
      for (int b = 0; b < W; b++) begin
        if (which == 0) q0.push_back({d[W-1-b], (b == W-1) ? 1'b1 : 1'b0});
        else            q1.push_back({d[b],     (b == W-1) ? 1'b1 : 1'b0});
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      #1;
      ok = !v0 && !v1 && fc0 == 0 && fc1 == 0 && q0.size() == 0 && q1.size() == 0;
    end
    if (!ok) check("wait idle timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int run;
    int nval;
    bit found;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    check("reset out",       o0, 1'b0);
    check("reset out_valid", v0, 1'b0);
    check("reset last",      l0, 1'b0);
    check("reset in_ready",  if0.in_ready, 1'b1);
    check("reset fifo_count", fc0, 3'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Single word A5, with first-bit latency
    push(0, 8'hA5);
    @(negedge CLK); #1;
    check("latency no bit before k+1", v0, 1'b0);
    @(negedge CLK); #1;
    check("latency first bit valid", v0, 1'b1);
    check("latency first bit value", o0, 1'b1);
    wait_idle();
    check("after A5 out_valid", v0, 1'b0);

    // Back-to-back words produce 16 contiguous bits
    push(0, 8'h0F);
    push(0, 8'hF0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK); #1;
      found = v0;
    end
    run = 0;
    while (v0 && run < 40) begin
      run++;
      @(negedge CLK); #1;
    end
    check("back-to-back run length", run, 16);
    wait_idle();

    // Overfill: hold each of six words until accepted
    rec_en = 1'b1;
    for (int w = 1; w <= 6; w++) push(0, W'(w));
    wait_idle();
    rec_en = 1'b0;
    check("max fifo_count", max_cnt, 4);
    check("in_ready dropped when full", saw_notready, 1'b1);
    check("reload transition seen", trans_seen > 0, 1'b1);
    check("drained fifo_count", fc0, 3'd0);
    check("drained in_ready", if0.in_ready, 1'b1);

    // Asynchronous reset mid-word after bit 3 of C3
    push(0, 8'hC3);
    repeat (4) @(negedge CLK);
    #2;
    check("C3 shifting before reset", v0, 1'b1);
    RESET = 1'b0;
    #1;
    check("async reset out",       o0, 1'b0);
    check("async reset out_valid", v0, 1'b0);
    check("async reset last",      l0, 1'b0);
    q0.delete();
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("post reset fifo_count", fc0, 3'd0);
    nval = 0;
    repeat (12) begin
      @(negedge CLK); #1;
      if (v0) nval++;
    end
    check("aborted word bits after reset", nval, 0);

    // LSB-first instance
    push(1, 8'h01);
    wait_idle();
    check("lsb-first bits emitted", pops1, 8);
    check("scoreboard dut0 empty", q0.size(), 0);
    check("scoreboard dut1 empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
